uart_fifo_ctrl: RTL and testbench
=================================

Name: uart_fifo_ctrl

Overview:
Memory-mapped UART peripheral with parametrised TX/RX FIFOs, a runtime-programmable baud divisor, sticky error flags and an interrupt output. It sits on the CPU data-memory bus beside the other MMIO peripherals. It contains its own bit-level transmitter and receiver, so firmware can queue several bytes without polling after every byte.

Parameters:
BASE_ADDR, 32'h40000018, base of the 5-word register window
DATA_BITS, 8, payload bits per frame (5..8)
TX_DEPTH, 16, TX FIFO entries (power of two, >=2)
RX_DEPTH, 16, RX FIFO entries (power of two, >=2)
DEFAULT_DIVISOR, 8802, clocks per bit after reset

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rx  in  1  serial input, asynchronous to clk
mem_read  in  1  bus read strobe
mem_write  in  1  bus write strobe
address  in  32  byte address
data_in  in  32  write data
uart_data  out  32  read data, combinational; 0 when not selected
tx  out  1  serial output, idle high
irq  out  1  level interrupt

Behaviour:
- Register map (offsets from BASE_ADDR):
  - 0x00 TXDATA (W): push data_in[DATA_BITS-1:0].
  - 0x04 RXDATA (R): head byte, zero-extended; pops.
  - 0x08 STATUS (R): [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] tx_busy, [5] rx_overrun, [6] frame_err, [7] tx_overflow, [8] parity_err, [23:16] rx_count. Bits 5-8 are sticky and cleared at the edge on which STATUS is read.
  - 0x0C DIVISOR (R/W): [15:0] clocks per bit; written values below 2 are stored as 2.
  - 0x10 CTRL (R/W): [0] rx_ie, [1] tx_ie, [2] parity_odd.
- Reset values: tx=1, irq=0, both FIFOs empty, sticky bits 0, DIVISOR=DEFAULT_DIVISOR, CTRL=0. Reset mid-frame aborts the frame and drives tx high asynchronously.
- Bus side effects occur once per clock edge while the strobe is high, so a multi-cycle strobe pops or pushes multiple times.
- TX write with FIFO full: data dropped, tx_overflow set.
- RXDATA read with FIFO empty: returns 0, no pop.
- Simultaneous FIFO push and pop on a full RX FIFO: the pop happens first, the push succeeds, no overrun.
- TX FSM IDLE->START->DATA->(PARITY)->STOP->IDLE, one bit period = latched divisor clocks, LSB first.
  - Divisor and parity mode are latched at the START entry; a DIVISOR write mid-frame affects the next frame only.
  - IDLE pops the FIFO head one cycle after the FIFO is non-empty, giving one idle clock between frames minimum.
  - tx_busy is high in every state except IDLE.
- RX path: 2-flop synchroniser on rx. FSM IDLE->START->DATA->(PARITY)->STOP.
  - IDLE->START on a synced falling edge.
  - START re-samples at divisor/2; a high sample returns to IDLE (glitch rejected).
  - Later samples are taken every divisor clocks.
  - STOP sampled low: frame_err set, byte discarded, FSM waits for the line to go high before IDLE.
  - Valid byte with RX FIFO full: byte discarded, rx_overrun set.
  - The byte is pushed on the cycle after the STOP sample.
- irq = (rx_ie & !rx_empty) | (tx_ie & tx_empty), registered, one-cycle latency.

Optional Feature:
UART_PARITY_EN:
- Defined: a parity bit is inserted after data (even parity, or odd when CTRL[2]=1). RX checks parity; on mismatch it sets parity_err and discards the byte.
- Undefined: no parity bit in the frame, STATUS[8] and CTRL[2] read 0, and CTRL[2] writes are ignored.

Test Plan:
- Reset, then read STATUS -> 0x00000005, tx=1, DIVISOR reads 8802.
- DIVISOR=4, write 0x55, 0xA3 -> tx shows two 40-clock frames (start 0, LSB-first data, stop 1), tx_busy high during frames, tx_empty set after the first pop.
- DIVISOR=4, drive serial 0x3C on rx -> rx_count=1, RXDATA=0x3C, rx_empty=1 afterwards; a second RXDATA read returns 0.
- Send RX_DEPTH+1 bytes without reading -> rx_full=1, rx_overrun=1, FIFO holds the first 16; STATUS read clears overrun only.
- Drive rx low through the stop bit -> frame_err=1, no push; a 1-clock low glitch on idle rx -> no frame started.
- CTRL=0x2 with TX idle -> irq=1; write TXDATA 0x11 -> irq drops within 2 clocks. Write 17 bytes -> tx_overflow=1. With UART_PARITY_EN, a bad parity bit sets parity_err.

Source files
------------

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: memory-mapped UART with TX/RX FIFOs, runtime baud divisor,
// sticky error flags and a level interrupt.
// Optional feature macro: UART_PARITY_EN adds a parity bit to each frame
// (even, or odd when CTRL[2]=1) and enables RX parity checking.
`timescale 1ns/1ps
module uart_fifo_ctrl #(
  parameter logic [31:0] BASE_ADDR       = 32'h4000_0018,
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned TX_DEPTH        = 16,
  parameter int unsigned RX_DEPTH        = 16,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd8802
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] uart_data,
  output logic        tx,
  output logic        irq
);
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned BIT_W = 3;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rx_state_e;

  // Register-window decode; side effects happen on every edge a strobe is high.
  logic [31:0] offset;
  logic        sel, wr_tx, rd_rx, rd_st, wr_div, wr_ctl;
  assign offset = address - BASE_ADDR;
  assign sel    = (offset < 32'd20) && (offset[1:0] == 2'b00);
  assign wr_tx  = sel && mem_write && (offset[4:2] == 3'd0);
  assign rd_rx  = sel && mem_read  && (offset[4:2] == 3'd1);
  assign rd_st  = sel && mem_read  && (offset[4:2] == 3'd2);
  assign wr_div = sel && mem_write && (offset[4:2] == 3'd3);
  assign wr_ctl = sel && mem_write && (offset[4:2] == 3'd4);

  logic unused_ok;
  assign unused_ok = ^data_in[31:16];

  logic [15:0] div_q;
  logic        rx_ie_q, tx_ie_q, par_odd_q;
  logic        ovr_q, ferr_q, txov_q, perr_q;
  logic        irq_q, tx_q;

  // FIFO storage and pointers (extra MSB distinguishes full from empty).
  logic [DATA_BITS-1:0] tx_mem_q [TX_DEPTH];
  logic [DATA_BITS-1:0] rx_mem_q [RX_DEPTH];
  logic [TX_AW:0]       tx_wp_q, tx_rp_q, tx_count;
  logic [RX_AW:0]       rx_wp_q, rx_rp_q, rx_count;
  logic                 tx_empty, tx_full, rx_empty, rx_full;
  logic                 tx_push, tx_pop, rx_push, rx_pop, rx_push_q;
  logic [DATA_BITS-1:0] tx_head, rx_shift_q;

  assign tx_count = tx_wp_q - tx_rp_q;
  assign rx_count = rx_wp_q - rx_rp_q;
  assign tx_empty = (tx_count == '0);
  assign rx_empty = (rx_count == '0);
  assign tx_full  = (tx_count == (TX_AW+1)'(TX_DEPTH));
  assign rx_full  = (rx_count == (RX_AW+1)'(RX_DEPTH));
  assign tx_head  = tx_mem_q[tx_rp_q[TX_AW-1:0]];
  assign tx_push  = wr_tx && !tx_full;
  assign rx_pop   = rd_rx && !rx_empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign rx_push  = rx_push_q && (!rx_full || rx_pop);

  // FIFO memories (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q[TX_AW-1:0]] <= data_in[DATA_BITS-1:0];
    if (rx_push) rx_mem_q[rx_wp_q[RX_AW-1:0]] <= rx_shift_q;
  end

  // FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp_q <= '0; tx_rp_q <= '0; rx_wp_q <= '0; rx_rp_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
    end
  end

  logic ferr_set, perr_set, rx_done;

  // Config registers, sticky flags (set wins over read-clear) and interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= DEFAULT_DIVISOR;
      rx_ie_q <= 1'b0; tx_ie_q <= 1'b0; par_odd_q <= 1'b0;
      ovr_q <= 1'b0; ferr_q <= 1'b0; txov_q <= 1'b0; perr_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_div) div_q <= (data_in[15:0] < 16'd2) ? 16'd2 : data_in[15:0];
      if (wr_ctl) begin
        rx_ie_q   <= data_in[0];
        tx_ie_q   <= data_in[1];
        par_odd_q <= PAR_EN & data_in[2];
      end
      ovr_q  <= (ovr_q  & ~rd_st) | (rx_push_q && rx_full && !rx_pop);
      ferr_q <= (ferr_q & ~rd_st) | ferr_set;
      txov_q <= (txov_q & ~rd_st) | (wr_tx && tx_full);
      perr_q <= (perr_q & ~rd_st) | (PAR_EN & perr_set);
      irq_q  <= (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_empty);
    end
  end

  // ---------------- Transmitter ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [15:0]          tx_cnt_q, tx_div_q;
  logic [BIT_W-1:0]     tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q, tx_tick, tx_d, tx_busy;
  assign tx_tick = (tx_cnt_q == tx_div_q - 16'd1);

  // TX state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state_q <= TX_IDLE;
    else     tx_state_q <= tx_state_d;
  end

  // TX next-state logic.
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:   if (!tx_empty) tx_state_d = TX_START;
      TX_START:  if (tx_tick) tx_state_d = TX_DATA;
      TX_DATA:   if (tx_tick && tx_bit_q == LAST_BIT) begin
                   if (PAR_EN) tx_state_d = TX_PARITY;
                   else        tx_state_d = TX_STOP;
                 end
      TX_PARITY: if (tx_tick) tx_state_d = TX_STOP;
      TX_STOP:   if (tx_tick) tx_state_d = TX_IDLE;
      default:   tx_state_d = TX_IDLE;
    endcase
  end

  // TX outputs: FIFO pop, line level, busy.
  always_comb begin
    tx_pop  = (tx_state_q == TX_IDLE) && !tx_empty;
    tx_busy = (tx_state_q != TX_IDLE);
    tx_d    = 1'b1;
    case (tx_state_q)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_shift_q[0];
      TX_PARITY: tx_d = tx_par_q;
      default:   tx_d = 1'b1;
    endcase
  end

  // TX datapath: frame settings latched at pop, bit timer, shifter, line register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt_q <= '0; tx_div_q <= DEFAULT_DIVISOR; tx_bit_q <= '0;
      tx_shift_q <= '0; tx_par_q <= 1'b0; tx_q <= 1'b1;
    end else begin
      tx_q <= tx_d;
      if (tx_state_q == TX_IDLE) begin
        tx_cnt_q <= '0;
        if (tx_pop) begin
          tx_shift_q <= tx_head;
          tx_div_q   <= div_q;
          tx_par_q   <= (^tx_head) ^ par_odd_q;
          tx_bit_q   <= '0;
        end
      end else if (tx_tick) begin
        tx_cnt_q <= '0;
        if (tx_state_q == TX_DATA) begin
          tx_shift_q <= tx_shift_q >> 1;
          tx_bit_q   <= tx_bit_q + 1'b1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 16'd1;
      end
    end
  end

  // ---------------- Receiver ----------------
  rx_state_e        rx_state_q, rx_state_d;
  logic             rx_s1_q, rx_s2_q, rx_prev_q, rx_fall;
  logic [15:0]      rx_cnt_q, rx_div_q, rx_half;
  logic [BIT_W-1:0] rx_bit_q;
  logic             rx_odd_q, rx_pbad_q, rx_tick, rx_tick_half;
  assign rx_fall      = rx_prev_q & ~rx_s2_q;
  assign rx_half      = {1'b0, rx_div_q[15:1]};
  assign rx_tick      = (rx_cnt_q == rx_div_q - 16'd1);
  assign rx_tick_half = (rx_cnt_q == rx_half - 16'd1);

  // RX state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state_q <= RX_IDLE;
    else     rx_state_q <= rx_state_d;
  end

  // RX next-state logic; a high mid-start sample is treated as a glitch.
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:   if (rx_fall) rx_state_d = RX_START;
      RX_START:  if (rx_tick_half) rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_tick && rx_bit_q == LAST_BIT) begin
                   if (PAR_EN) rx_state_d = RX_PARITY;
                   else        rx_state_d = RX_STOP;
                 end
      RX_PARITY: if (rx_tick) rx_state_d = RX_STOP;
      RX_STOP:   if (rx_tick) rx_state_d = rx_s2_q ? RX_IDLE : RX_WAIT;
      RX_WAIT:   if (rx_s2_q) rx_state_d = RX_IDLE;
      default:   rx_state_d = RX_IDLE;
    endcase
  end

  // RX outputs: stop-bit outcome (error flags or byte ready).
  always_comb begin
    rx_done  = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    if (rx_state_q == RX_STOP && rx_tick) begin
      if (!rx_s2_q)       ferr_set = 1'b1;
      else if (rx_pbad_q) perr_set = 1'b1;
      else                rx_done  = 1'b1;
    end
  end

  // RX datapath: synchroniser, bit timer, shifter, parity check, delayed push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
      rx_cnt_q <= '0; rx_bit_q <= '0; rx_shift_q <= '0; rx_div_q <= DEFAULT_DIVISOR;
      rx_odd_q <= 1'b0; rx_pbad_q <= 1'b0; rx_push_q <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_push_q <= rx_done;
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0; rx_bit_q <= '0; rx_pbad_q <= 1'b0;
          if (rx_fall) begin
            rx_div_q <= div_q;
            rx_odd_q <= par_odd_q;
          end
        end
        RX_START: rx_cnt_q <= rx_tick_half ? 16'd0 : rx_cnt_q + 16'd1;
        RX_WAIT:  rx_cnt_q <= '0;
        default: begin
          rx_cnt_q <= rx_tick ? 16'd0 : rx_cnt_q + 16'd1;
          if (rx_tick && rx_state_q == RX_DATA) begin
            rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
            rx_bit_q   <= rx_bit_q + 1'b1;
          end
          if (rx_tick && rx_state_q == RX_PARITY)
            rx_pbad_q <= rx_s2_q ^ (^rx_shift_q) ^ rx_odd_q;
        end
      endcase
    end
  end

  // Combinational read mux; zero when not addressed.
  always_comb begin
    uart_data = 32'd0;
    if (sel && mem_read) begin
      case (offset[4:2])
        3'd1: uart_data = rx_empty ? 32'd0 : 32'(rx_mem_q[rx_rp_q[RX_AW-1:0]]);
        3'd2: uart_data = {8'd0, 8'(rx_count), 7'd0, perr_q, txov_q, ferr_q, ovr_q,
                           tx_busy, rx_full, rx_empty, tx_full, tx_empty};
        3'd3: uart_data = {16'd0, div_q};
        3'd4: uart_data = {29'd0, par_odd_q, tx_ie_q, rx_ie_q};
        default: uart_data = 32'd0;
      endcase
    end
  end

  assign tx  = tx_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed self-checking bench for uart_fifo_ctrl (divisor 4 for serial tests).
`timescale 1ns/1ps
module tb_uart_fifo_ctrl;
  localparam logic [31:0] BASE = 32'h4000_0018;
  localparam logic [31:0] A_TX = 32'h00, A_RX = 32'h04, A_ST = 32'h08,
                          A_DIV = 32'h0C, A_CTL = 32'h10;
`ifdef UART_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FB = PAR ? 11 : 10;

  logic        clk = 1'b0, rst = 1'b1, rx = 1'b1, mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] address = '0, data_in = '0, uart_data;
  logic        tx, irq;
  int          n_checks = 0, n_errors = 0, cyc = 0;
  logic [31:0] rd;

  uart_fifo_ctrl dut (
    .clk(clk), .rst(rst), .rx(rx), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .data_in(data_in), .uart_data(uart_data), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] off, input logic [31:0] d);
    @(negedge clk);
    address = BASE + off; data_in = d; mem_write = 1'b1;
    @(posedge clk); #1;
    mem_write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] off, output logic [31:0] d);
    @(negedge clk);
    address = BASE + off; mem_read = 1'b1;
    #1 d = uart_data;
    @(posedge clk); #1;
    mem_read = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(off, v);
    check_eq(tag, v, exp);
  endtask

  // Drive one serial frame on rx, 4 clocks per bit, changing on falling edges.
  task automatic send_rx(input logic [7:0] b, input logic stop_b, input logic par_flip);
    logic [10:0] f;
    logic        pbit;
    pbit = (^b) ^ par_flip;
    if (PAR) f = {stop_b, pbit, b, 1'b0};
    else     f = {1'b0, stop_b, b, 1'b0};
    for (int i = 0; i < FB; i++) begin
      @(negedge clk); rx = f[i];
      repeat (3) @(negedge clk);
    end
  endtask

  function automatic logic [10:0] tx_frame_exp(input logic [7:0] d);
    if (PAR) return {1'b1, ^d, d, 1'b0};
    return {2'b01, d, 1'b0};
  endfunction

  // Serial monitor on tx: mid-bit sampling at divisor 4, records frames and start cycles.
  logic [10:0] frm_q[$];
  int          frm_t[$];
  logic [10:0] mon_f;
  int          mon_t0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst && tx === 1'b0) begin
        mon_t0 = cyc;
        mon_f  = '0;
        for (int k = 0; k < FB; k++) begin
          if (k == 0) repeat (2) @(posedge clk);
          else        repeat (4) @(posedge clk);
          #1 mon_f[k] = tx;
        end
        frm_q.push_back(mon_f);
        frm_t.push_back(mon_t0);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    @(posedge clk); #1;
    check_eq("reset_tx", 32'(tx), 32'd1);
    check_eq("reset_irq", 32'(irq), 32'd0);
    rd_chk("reset_status", A_ST, 32'h0000_0005);
    rd_chk("reset_divisor", A_DIV, 32'd8802);
    rd_chk("reset_ctrl", A_CTL, 32'd0);
    rd_chk("unmapped_read", 32'h14, 32'd0);

    // Divisor floor, then fast baud
    bus_write(A_DIV, 32'd1);
    rd_chk("divisor_floor", A_DIV, 32'd2);
    bus_write(A_DIV, 32'd4);
    rd_chk("divisor_4", A_DIV, 32'd4);

    // Two TX frames
    bus_write(A_TX, 32'h55);
    @(posedge clk);
    rd_chk("status_tx_busy_empty", A_ST, 32'h0000_0015);
    bus_write(A_TX, 32'hA3);
    for (int i = 0; i < 400 && frm_q.size() < 2; i++) @(posedge clk);
    check_eq("tx_frame_count", 32'(frm_q.size()), 32'd2);
    if (frm_q.size() >= 2) begin
      check_eq("tx_frame0", 32'(frm_q[0]), 32'(tx_frame_exp(8'h55)));
      check_eq("tx_frame1", 32'(frm_q[1]), 32'(tx_frame_exp(8'hA3)));
      check_eq("tx_frame_gap", 32'(frm_t[1] - frm_t[0]), 32'(FB * 4 + 1));
    end
    repeat (10) @(posedge clk);
    rd_chk("status_tx_done", A_ST, 32'h0000_0005);

    // Single RX byte
    send_rx(8'h3C, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    rd_chk("rx_one_status", A_ST, 32'h0001_0001);
    rd_chk("rx_one_data", A_RX, 32'h0000_003C);
    rd_chk("rx_one_after", A_ST, 32'h0000_0005);
    rd_chk("rx_empty_read", A_RX, 32'd0);

    // RX overrun: 17 frames, first 16 kept
    for (int i = 0; i < 17; i++) send_rx(8'(8'h10 + i), 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    rd_chk("rx_overrun_status", A_ST, 32'h0010_0029);
    rd_chk("rx_overrun_cleared", A_ST, 32'h0010_0009);
    for (int i = 0; i < 16; i++) rd_chk("rx_fifo_data", A_RX, 32'(8'h10 + i));
    rd_chk("rx_drained", A_ST, 32'h0000_0005);

    // Framing error, then idle-line glitch, then recovery frame
    send_rx(8'h5A, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(posedge clk);
    rd_chk("frame_err_status", A_ST, 32'h0000_0045);
    rd_chk("frame_err_cleared", A_ST, 32'h0000_0005);
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (20) @(posedge clk);
    rd_chk("glitch_rejected", A_ST, 32'h0000_0005);
    send_rx(8'hA5, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    rd_chk("rx_recovered", A_RX, 32'h0000_00A5);

`ifdef UART_PARITY_EN
    send_rx(8'h33, 1'b1, 1'b1);
    repeat (6) @(posedge clk);
    rd_chk("parity_err_status", A_ST, 32'h0000_0105);
`endif

    // TX-empty interrupt
    bus_write(A_CTL, 32'h2);
    repeat (2) @(posedge clk); #1;
    check_eq("irq_tx_empty", 32'(irq), 32'd1);
    bus_write(A_TX, 32'h11);
    @(posedge clk); #1;
    check_eq("irq_drop", 32'(irq), 32'd0);
    rd_chk("ctrl_readback", A_CTL, 32'h2);

    // TX overflow while the first frame is still on the line
    for (int i = 0; i < 17; i++) bus_write(A_TX, 32'(i));
    rd_chk("tx_overflow_status", A_ST, 32'h0000_0096);
    rd_chk("tx_overflow_cleared", A_ST, 32'h0000_0016);

    // Asynchronous reset mid-frame forces tx high immediately
    for (int i = 0; i < 100 && tx !== 1'b0; i++) begin @(posedge clk); #1; end
    check_eq("tx_low_seen", 32'(tx), 32'd0);
    #2 rst = 1'b1;
    #1 check_eq("tx_async_reset", 32'(tx), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_chk("post_reset_status", A_ST, 32'h0000_0005);
    rd_chk("post_reset_divisor", A_DIV, 32'd8802);
    rd_chk("post_reset_ctrl", A_CTL, 32'd0);
    @(posedge clk); #1;
    check_eq("post_reset_irq", 32'(irq), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
